alu_op_sequencer: RTL

Multi-cycle control stage that sits directly upstream of the 19-bit ALU. It accepts opcode commands over a valid/ready handshake and, when the operation needs one, fetches the DR operand from memory over a req/ack handshake. It then drives exactly one ALU operation strobe for one cycle and writes the ALU result back into the accumulator (AC) it owns. It also maintains the zero, negative and sticky-overflow status flags.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_op_decoder.sv | 19 +
 rtl/alu_op_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: widths, opcodes,
// FSM state type and the operand-fetch classification of each opcode.
package alu_seq_pkg;

    localparam int DATA_W_DEF  = 19;
    localparam int ADDR_W_DEF  = 10;
    localparam int NUM_ALU_OPS = 14;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;
    localparam logic [3:0] OP_FFT = 4'd10;
    localparam logic [3:0] OP_ENC = 4'd11;
    localparam logic [3:0] OP_DNC = 4'd12;
    localparam logic [3:0] OP_TNF = 4'd13;
    localparam logic [3:0] OP_CLF = 4'd14;
    localparam logic [3:0] OP_CLR = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // Opcodes that consume a DR operand read from memory before executing
    function automatic logic needs_fetch(input logic [3:0] op);
        return (op <= OP_NOT) || ((op >= OP_ENC) && (op <= OP_TNF));
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Turns the latched opcode into the one-hot ALU strobe vector; the strobe
// is only raised while the sequencer is executing, and CLF/CLR raise none.
module alu_op_decoder
    import alu_seq_pkg::*;
(
    input  logic [3:0]             op,
    input  logic                   exec_valid,
    output logic [NUM_ALU_OPS-1:0] alu_sel
);

    // One strobe bit per ALU opcode, all low outside execution
    always_comb begin
        alu_sel = '0;
        for (int i = 0; i < NUM_ALU_OPS; i++) begin
            alu_sel[i] = exec_valid && (op == 4'(i));
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control stage in front of the ALU: accepts opcode commands, fetches the
// DR operand when needed, fires one ALU strobe and writes the result into
// the accumulator it owns, keeping zero/negative/sticky-overflow flags.
// Optional feature macro: ALU_SEQ_OVF_TRAP_EN (discard overflowing results
// and pulse ovf_trap alongside done).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_op,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic                   ac_wr_en,
    input  logic [DATA_W-1:0]      ac_wr_data,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [DATA_W-1:0]      ac,
    output logic [DATA_W-1:0]      dr,
    output logic [NUM_ALU_OPS-1:0] alu_sel,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic                   alu_ovf,
    output logic                   done,
    output logic                   zero_flag,
    output logic                   neg_flag,
    output logic                   ovf_sticky,
    output logic                   ovf_trap
);

    state_t              state;
    state_t              state_next;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                exec_valid;
    logic                accept;
    logic                ac_load;
    logic [DATA_W-1:0]   ac_next;
    logic                sticky_next;
`ifdef ALU_SEQ_OVF_TRAP_EN
    logic                trap_hit;
`endif

    assign accept = cmd_valid && cmd_ready;

    // State register, forced back to IDLE by reset even mid-fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fetch-class ops detour through FETCH until mem_ack
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = needs_fetch(cmd_op) ? FETCH : EXEC;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded handshake outputs; a host AC write blocks new commands
    always_comb begin
        cmd_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        exec_valid = 1'b0;
        case (state)
            IDLE:  cmd_ready = ~ac_wr_en;
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            EXEC:    exec_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture opcode and operand address when a command is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= '0;
            addr_q <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
        end
    end

    // DR only loads on the acknowledged fetch edge; stray acks are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dr <= '0;
        end else if ((state == FETCH) && mem_ack) begin
            dr <= mem_rdata;
        end
    end

    // Decide what the accumulator and sticky flag become at this edge
    always_comb begin
        ac_load     = 1'b0;
        ac_next     = ac;
        sticky_next = ovf_sticky;
`ifdef ALU_SEQ_OVF_TRAP_EN
        trap_hit    = 1'b0;
`endif
        if ((state == IDLE) && ac_wr_en) begin
            ac_load = 1'b1;
            ac_next = ac_wr_data;
        end else if (state == EXEC) begin
            if (op_q == OP_CLF) begin
                sticky_next = 1'b0;
            end else if (op_q == OP_CLR) begin
                ac_load     = 1'b1;
                ac_next     = '0;
                sticky_next = 1'b0;
            end else begin
                ac_next     = alu_result;
                sticky_next = ovf_sticky | alu_ovf;
`ifdef ALU_SEQ_OVF_TRAP_EN
                ac_load     = ~alu_ovf;
                trap_hit    = alu_ovf;
`else
                ac_load     = 1'b1;
`endif
            end
        end
    end

    // Accumulator with its status flags, plus the completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ac         <= '0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
            ovf_sticky <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (ac_load) begin
                ac        <= ac_next;
                zero_flag <= (ac_next == '0);
                neg_flag  <= ac_next[DATA_W-1];
            end
            ovf_sticky <= sticky_next;
            done       <= (state == EXEC);
        end
    end

`ifdef ALU_SEQ_OVF_TRAP_EN
    // Trap pulse lines up with done when an overflowing result was dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_trap <= 1'b0;
        end else begin
            ovf_trap <= trap_hit;
        end
    end
`else
    assign ovf_trap = 1'b0;
`endif

    alu_op_decoder u_decoder (
        .op         (op_q),
        .exec_valid (exec_valid),
        .alu_sel    (alu_sel)
    );

endmodule
